// File: rtl/therm_pkg.sv
// rtl/therm_pkg.sv - shared types and helpers for the thermometer sampler
package therm_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/therm_bubble_fix.sv
// rtl/therm_bubble_fix.sv - combinational 3-tap majority filter over a thermometer vector
module therm_bubble_fix
  import therm_pkg::*;
#(
  parameter int VECT_W = 8
) (
  input  logic [VECT_W-1:0] code,
  output logic [VECT_W-1:0] fixed
);

  // Below bit 0 reads as 1 and above the top bit reads as 0, so edges of a
  // clean thermometer code are preserved.
  logic [VECT_W+1:0] ext;

  assign ext = {1'b0, code, 1'b1};

  always_comb begin
    fixed = '0;
    for (int i = 0; i < VECT_W; i++) begin
      fixed[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end

endmodule

// File: rtl/therm_sampler.sv
// rtl/therm_sampler.sv - sync, bubble-fix and debounce of a flash comparator vector
module therm_sampler
  import therm_pkg::*;
#(
  parameter int VECT_W     = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VECT_W-1:0] raw,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [VECT_W-1:0] therm
);

  localparam int CNT_W = (clog2(STABLE_CNT) < 1) ? 1 : clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [VECT_W-1:0] s1, s2;
  logic [VECT_W-1:0] corr_d, corr_q;
  logic [VECT_W-1:0] last;
  logic [CNT_W-1:0]  cnt;
  logic              stable;
  logic              load_ok;
  logic              load_en;
  state_t            state, state_nxt;

  therm_bubble_fix #(.VECT_W(VECT_W)) u_fix (
    .code  (s2),
    .fixed (corr_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      corr_q <= '0;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      corr_q <= corr_d;
      if (corr_d != corr_q) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable  = (cnt == CNT_MAX);
  // last always equals therm while FULL, so this also excludes re-loading the held code.
  assign load_ok = stable && (corr_q != last);

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    load_en   = 1'b0;
    case (state)
      EMPTY: begin
        if (load_ok) begin
          load_en   = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (load_ok) load_en = 1'b1;
          else         state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      therm <= '0;
      last  <= '0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        therm <= corr_q;
        last  <= corr_q;
      end
    end
  end

endmodule
